// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between the
// instruction-fetch port and the data-access port. Each access takes two
// cycles (issue, then response). Data loads are lane-aligned and extended,
// stores are lane-steered, and misaligned or illegal data requests complete
// with an error and no memory access.
module mem_port_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    input  logic [2:0]       d_len,
    output logic             d_valid,
    output logic [WIDTH-1:0] d_rdata,
    output logic             d_err,
    output logic             stall,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_be,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        D_WAIT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;   // 1 = previous grant was data
    logic [1:0]  lane_q, lane_d;
    logic [2:0]  len_q, len_d;
    logic        err_q, err_d;
    logic        we_q, we_d;

    logic        grant_d;
    logic        grant_i;
    logic        d_half;
    logic        d_word;
    logic        d_illegal;
    logic        d_bad;

    // Fetch addresses are word-aligned by contract; their low bits carry nothing.
    logic        unused_if_lsbs;
    assign unused_if_lsbs = ^if_addr[1:0];

    // Shift the addressed lane down to bit 0, then sign- or zero-extend by length.
    function automatic logic [WIDTH-1:0] load_extend(
        input logic [WIDTH-1:0] raw,
        input logic [1:0]       lane,
        input logic [2:0]       len
    );
        logic [WIDTH-1:0]  shifted;
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        shifted = raw >> {lane, 3'b000};
        byte_s  = shifted[7:0];
        half_s  = shifted[15:0];
        case (len)
            3'b000:  load_extend = WIDTH'(byte_s);
            3'b001:  load_extend = WIDTH'(half_s);
            3'b100:  load_extend = WIDTH'(shifted[7:0]);
            3'b101:  load_extend = WIDTH'(shifted[15:0]);
            default: load_extend = shifted;
        endcase
    endfunction

    // Request decode and arbitration; data wins unless it won last time.
    always_comb begin
        d_half    = (d_len[1:0] == 2'b01);
        d_word    = (d_len == 3'b010);
        d_illegal = (d_len == 3'b011) || (d_len == 3'b110) || (d_len == 3'b111);
        d_bad     = d_illegal | (d_half & d_addr[0]) | (d_word & (|d_addr[1:0]));
        grant_d   = (state_q == IDLE) & d_req & (~if_req | ~last_grant_q);
        grant_i   = (state_q == IDLE) & if_req & ~grant_d;
    end

    // Memory issue strobes, driven only in the issue cycle of a good access.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = 4'b0000;
        if (grant_i) begin
            mem_en   = 1'b1;
            mem_addr = {if_addr[WIDTH-1:2], 2'b00};
            mem_be   = 4'b1111;
        end else if (grant_d && !d_bad) begin
            mem_en   = 1'b1;
            mem_we   = d_we;
            mem_addr = {d_addr[WIDTH-1:2], 2'b00};
            mem_be   = 4'b1111;
            if (d_we) begin
                case (d_len[1:0])
                    2'b00: begin
                        mem_wdata = {4{d_wdata[7:0]}};
                        mem_be    = 4'b0001 << d_addr[1:0];
                    end
                    2'b01: begin
                        mem_wdata = {2{d_wdata[15:0]}};
                        mem_be    = 4'b0011 << d_addr[1:0];
                    end
                    default: begin
                        mem_wdata = d_wdata;
                        mem_be    = 4'b1111;
                    end
                endcase
            end
        end
    end

    // Next-state logic: latch the access attributes at issue, return after one wait cycle.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lane_d       = lane_q;
        len_d        = len_q;
        err_d        = err_q;
        we_d         = we_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d      = D_WAIT;
                    last_grant_d = 1'b1;
                    lane_d       = d_addr[1:0];
                    len_d        = d_len;
                    err_d        = d_bad;
                    we_d         = d_we;
                end else if (grant_i) begin
                    state_d      = IF_WAIT;
                    last_grant_d = 1'b0;
                end
            end
            IF_WAIT: state_d = IDLE;
            D_WAIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            lane_q       <= 2'b00;
            len_q        <= 3'b000;
            err_q        <= 1'b0;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lane_q       <= lane_d;
            len_q        <= len_d;
            err_q        <= err_d;
            we_q         <= we_d;
        end
    end

    assign if_valid = (state_q == IF_WAIT);
    assign if_rdata = if_valid ? mem_rdata : '0;
    assign d_valid  = (state_q == D_WAIT);
    assign d_err    = d_valid & err_q;
    assign d_rdata  = (d_valid && !err_q && !we_q) ? load_extend(mem_rdata, lane_q, len_q) : '0;
    assign stall    = (if_req & ~if_valid) | (d_req & ~d_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a RAM model, a byte-level reference memory,
// directed scenarios and randomized request pairs, with a scoreboard monitor.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [2:0]  d_len = 3'b010;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        stall;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    mem_port_arbiter #(.WIDTH(32)) dut (
        .CLK(CLK), .RST(RST),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_len(d_len),
        .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err), .stall(stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    // Physical RAM: 256 words, byte-enabled write, registered read.
    logic [31:0] ram [0:255];
    always @(posedge CLK) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (mem_be[i]) ram[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
            mem_rdata <= ram[mem_addr[9:2]];
        end
    end

    // Reference model state: byte-addressed memory and last-granted requester.
    logic [7:0] refm [0:1023];
    bit         ref_last = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] fq [$];
    logic [32:0] dq [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_word(input int a);
        return {refm[a+3], refm[a+2], refm[a+1], refm[a]};
    endfunction

    task automatic set_word(input int idx, input logic [31:0] w);
        ram[idx] = w;
        for (int b = 0; b < 4; b++) refm[4*idx + b] = w[8*b +: 8];
    endtask

    // RISC-V load/store semantics applied to the byte memory.
    task automatic model_data(input logic we, input logic [2:0] len, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic err, output logic [31:0] rdata);
        int     size;
        int     a;
        longint v;
        a     = int'(addr[9:0]);
        size  = 1 << len[1:0];
        err   = (len == 3'd3) || (len == 3'd6) || (len == 3'd7) || ((a % size) != 0);
        rdata = '0;
        if (!err) begin
            if (we) begin
                for (int b = 0; b < size; b++) refm[a+b] = wdata[8*b +: 8];
            end else begin
                v = 0;
                for (int b = 0; b < size; b++) v = v + (longint'(refm[a+b]) << (8*b));
                if (!len[2] && size < 4 && v >= (longint'(1) << (8*size - 1)))
                    v = v - (longint'(1) << (8*size));
                rdata = v[31:0];
            end
        end
    endtask

    // Scoreboard monitor: pops an expectation whenever a response pulse appears.
    always @(negedge CLK) begin
        if (RST) begin
            if (if_valid) begin
                if (fq.size() == 0) begin
                    n_total++;
                    $display("FAIL if_unexpected: got if_valid with rdata 0x%08h, expected none", if_rdata);
                end else chk("if_rdata", if_rdata, fq.pop_front());
            end
            if (d_valid) begin
                if (dq.size() == 0) begin
                    n_total++;
                    $display("FAIL d_unexpected: got d_valid err=%0b rdata 0x%08h, expected none", d_err, d_rdata);
                end else chk("d_resp", {d_err, d_rdata}, dq.pop_front());
            end
        end
    end

    // Issue up to one fetch and one data request together and see both through.
    task automatic run_pair(input bit df, input bit ff, input logic we, input logic [2:0] len,
                            input logic [31:0] daddr, input logic [31:0] wdata, input logic [31:0] faddr);
        logic        err;
        logic [31:0] rd;
        int          fc, dc, t;
        bit          fdone, ddone;
        fc = 0; dc = 0;
        if (df) begin
            model_data(we, len, daddr, wdata, err, rd);
            dq.push_back({err, rd});
            d_we = we; d_len = len; d_addr = daddr; d_wdata = wdata; d_req = 1'b1;
        end
        if (ff) begin
            fq.push_back(ref_word(int'(faddr[9:0])));
            if_addr = faddr; if_req = 1'b1;
        end
        fdone = !ff; ddone = !df; t = 0;
        while (!(fdone && ddone) && t < 8) begin
            @(negedge CLK);
            t++;
            if (ff && !fdone && if_valid) begin fdone = 1; fc = t; end
            if (df && !ddone && d_valid) begin ddone = 1; dc = t; end
            @(posedge CLK); #1;
            if (fdone) if_req = 1'b0;
            if (ddone) d_req = 1'b0;
        end
        if (!(fdone && ddone)) begin
            n_total++;
            $display("FAIL pair_timeout: fetch_done=%0b data_done=%0b, required both", fdone, ddone);
            if_req = 1'b0; d_req = 1'b0;
        end else if (df && ff) begin
            if (ref_last) chk("order_fetch_first", {fc, dc}, {32'd2, 32'd4});
            else          chk("order_data_first",  {fc, dc}, {32'd4, 32'd2});
        end else if (df) begin
            chk("data_latency", dc, 2);
            ref_last = 1'b1;
        end else begin
            chk("fetch_latency", fc, 2);
            ref_last = 1'b0;
        end
    endtask

    // Directed single data access with issue-cycle and response-cycle checks.
    task automatic d_directed(input string nm, input logic we, input logic [2:0] len,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic exp_en, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                              input logic exp_err, input logic [31:0] exp_rd);
        logic        err;
        logic [31:0] rd;
        model_data(we, len, addr, wdata, err, rd);
        dq.push_back({exp_err, exp_rd});
        d_we = we; d_len = len; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        @(negedge CLK);
        if (exp_en) chk({nm, "_issue"}, {mem_en, mem_we, mem_be, mem_addr}, {1'b1, we, exp_be, addr[31:2], 2'b00});
        else        chk({nm, "_no_mem_en"}, mem_en, 1'b0);
        if (exp_en && we) chk({nm, "_wdata"}, mem_wdata, exp_wd);
        @(negedge CLK);
        chk({nm, "_valid"}, {d_valid, stall}, 2'b10);
        @(posedge CLK); #1;
        d_req = 1'b0;
        ref_last = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        int bad;
        logic        err;
        logic [31:0] rd;
        for (int i = 0; i < 256; i++) set_word(i, $urandom);
        set_word(32'h100 >> 2, 32'h00500093);
        set_word(32'h200 >> 2, 32'h00000000);

        // Reset state
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset_ctrl", {if_valid, d_valid, d_err, mem_en, mem_we, mem_be, stall}, 10'd0);
        chk("reset_rdata", {if_rdata, d_rdata}, 64'd0);
        RST = 1'b1;
        @(posedge CLK); #1;

        // Fetch only
        fq.push_back(32'h00500093);
        if_addr = 32'h100; if_req = 1'b1;
        @(negedge CLK);
        chk("fetch_issue", {mem_en, mem_we, mem_be, stall, mem_addr}, {1'b1, 1'b0, 4'hF, 1'b1, 32'h100});
        @(negedge CLK);
        chk("fetch_valid", {if_valid, stall}, 2'b10);
        @(posedge CLK); #1;
        if_req = 1'b0;
        ref_last = 1'b0;

        // Contention with last grant = fetch: data first
        dq.push_back({1'b0, 32'h0});
        fq.push_back(32'h00500093);
        d_we = 1'b0; d_len = 3'b010; d_addr = 32'h200; d_req = 1'b1;
        if_addr = 32'h100; if_req = 1'b1;
        @(negedge CLK);
        chk("cont_n0", {mem_en, mem_we, stall, mem_addr}, {1'b1, 1'b0, 1'b1, 32'h200});
        @(negedge CLK);
        chk("cont_n1", {d_valid, if_valid, stall}, 3'b101);
        @(posedge CLK); #1;
        d_req = 1'b0;
        @(negedge CLK);
        chk("cont_n2", {mem_en, stall, mem_addr}, {1'b1, 1'b1, 32'h100});
        @(negedge CLK);
        chk("cont_n3", {if_valid, stall}, 2'b10);
        @(posedge CLK); #1;
        if_req = 1'b0;
        ref_last = 1'b0;

        // Contention with last grant = data: fetch first
        run_pair(1, 0, 1'b0, 3'b010, 32'h200, 32'h0, 32'h0);
        run_pair(1, 1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h100);

        // Stores
        d_directed("sb", 1'b1, 3'b000, 32'h201, 32'hFFFFFFAB, 1'b1, 4'b0010, 32'hABABABAB, 1'b0, 32'h0);
        chk("sb_word", ram[32'h200 >> 2], 32'h0000AB00);
        d_directed("sh", 1'b1, 3'b001, 32'h202, 32'hFFFF1234, 1'b1, 4'b1100, 32'h12341234, 1'b0, 32'h0);
        chk("sh_word", ram[32'h200 >> 2], 32'h1234AB00);
        d_directed("sw", 1'b1, 3'b010, 32'h200, 32'h80FF7F01, 1'b1, 4'b1111, 32'h80FF7F01, 1'b0, 32'h0);
        chk("sw_word", ram[32'h200 >> 2], 32'h80FF7F01);

        // Loads
        d_directed("lb_201",  1'b0, 3'b000, 32'h201, 32'h0, 1'b1, 4'hF, 32'h0, 1'b0, 32'h0000007F);
        d_directed("lb_202",  1'b0, 3'b000, 32'h202, 32'h0, 1'b1, 4'hF, 32'h0, 1'b0, 32'hFFFFFFFF);
        d_directed("lbu_203", 1'b0, 3'b100, 32'h203, 32'h0, 1'b1, 4'hF, 32'h0, 1'b0, 32'h00000080);
        d_directed("lh_202",  1'b0, 3'b001, 32'h202, 32'h0, 1'b1, 4'hF, 32'h0, 1'b0, 32'hFFFF80FF);
        d_directed("lhu_202", 1'b0, 3'b101, 32'h202, 32'h0, 1'b1, 4'hF, 32'h0, 1'b0, 32'h000080FF);
        d_directed("lw_200",  1'b0, 3'b010, 32'h200, 32'h0, 1'b1, 4'hF, 32'h0, 1'b0, 32'h80FF7F01);

        // Error cases
        d_directed("lw_mis",  1'b0, 3'b010, 32'h202, 32'h0,    1'b0, 4'h0, 32'h0, 1'b1, 32'h0);
        d_directed("sh_mis",  1'b1, 3'b001, 32'h203, 32'h5555, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0);
        d_directed("len_011", 1'b1, 3'b011, 32'h200, 32'h1111, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0);
        chk("err_mem_unchanged", ram[32'h200 >> 2], 32'h80FF7F01);

        // Reset during D_WAIT, then re-issue of the held request
        d_we = 1'b0; d_len = 3'b010; d_addr = 32'h200; d_req = 1'b1;
        @(negedge CLK);
        chk("rst_mid_issue", mem_en, 1'b1);
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        chk("rst_mid_abort", {d_valid, d_err, stall, d_rdata}, {1'b0, 1'b0, 1'b1, 32'h0});
        @(negedge CLK);
        RST = 1'b1;
        ref_last = 1'b0;
        model_data(1'b0, 3'b010, 32'h200, 32'h0, err, rd);
        dq.push_back({err, rd});
        t = 0;
        do begin
            @(negedge CLK);
            t++;
        end while (!d_valid && t < 6);
        chk("rst_reissue_latency", t, 1);
        @(posedge CLK); #1;
        d_req = 1'b0;
        ref_last = 1'b1;

        // Randomized request pairs
        for (int it = 0; it < 120; it++) begin
            bit df, ff;
            df = ($urandom_range(0, 3) != 0);
            ff = ($urandom_range(0, 2) != 0);
            if (!df && !ff) ff = 1;
            run_pair(df, ff, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                     32'h200 + 32'($urandom_range(0, 255)), $urandom,
                     32'($urandom_range(0, 127)) << 2);
            repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
        end

        repeat (2) @(posedge CLK);
        #1;
        bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== ref_word(4*i)) bad++;
        chk("ram_final_mismatches", bad, 0);
        chk("queues_drained", fq.size() + dq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous memory between the processor's instruction-fetch port and data-access port. It arbitrates requests and runs a per-access two-cycle state machine. It performs byte-lane steering, alignment and sign-extension for RISC-V load/store lengths, and produces the pipeline stall that freezes PC and IF/ID while an access is outstanding. It sits between `processor` and a unified instruction/data RAM.

## Interface
Parameters:
- `WIDTH`, 32: data and address width. Only 32 is supported.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: reset, asynchronous, active-low.
- `if_req` in 1: fetch request. It is held until `if_valid`.
- `if_addr` in WIDTH: fetch address. It must be word-aligned.
- `if_valid` out 1: fetch data valid, one-cycle pulse.
- `if_rdata` out WIDTH: fetched instruction. It is 0 when `if_valid`=0.
- `d_req` in 1: data request (MemRead|MemWrite). It is held until `d_valid`.
- `d_we` in 1: 1 means store, 0 means load.
- `d_addr` in WIDTH: byte address.
- `d_wdata` in WIDTH: store data, right-justified.
- `d_len` in 3: funct3 encoding. 000 = lb, 001 = lh, 010 = lw, 100 = lbu, 101 = lhu.
- `d_valid` out 1: data access complete, one-cycle pulse.
- `d_rdata` out WIDTH: load result, aligned and extended. It is 0 when `d_valid`=0 or on a store.
- `d_err` out 1: misaligned or illegal `d_len`. It is meaningful only with `d_valid`.
- `stall` out 1: `(if_req & ~if_valid) | (d_req & ~d_valid)`.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write.
- `mem_addr` out WIDTH: word address `{addr[WIDTH-1:2],2'b00}`.
- `mem_wdata` out WIDTH: lane-steered store data.
- `mem_be` out 4: byte enables. Bit i selects `mem_wdata[8i+7:8i]`.
- `mem_rdata` in WIDTH: read data, valid the cycle after `mem_en`.

## Operation
- FSM states and transitions:
  - `IDLE`: issues at most one access per cycle, then moves to `IF_WAIT` or `D_WAIT`.
  - `IF_WAIT`: asserts `if_valid`, returns to `IDLE`.
  - `D_WAIT`: asserts `d_valid`, returns to `IDLE`.
- Arbitration in `IDLE`:
  - Only `d_req` pending: data wins.
  - Only `if_req` pending: fetch wins.
  - Both pending: data wins, unless the previous grant was data. In that case fetch wins. This alternates and prevents fetch starvation.
  - `last_grant` register resets to fetch.
- Issue signals are combinational in `IDLE` from the winning request: `mem_en`, `mem_addr`, `mem_we`, `mem_be`, `mem_wdata`. In every other state they are 0.
- Fetch issue: `mem_we`=0, `mem_be`=1111.
- Store lane steering:
  - sb: `mem_wdata={4{wdata[7:0]}}`, `mem_be=0001<<addr[1:0]`.
  - sh: `mem_wdata={2{wdata[15:0]}}`, `mem_be=0011<<addr[1:0]`.
  - sw: `mem_wdata=wdata`, `mem_be=1111`.
- Load: `mem_be`=1111. `addr[1:0]` and `d_len` are latched at issue. In `D_WAIT`, `mem_rdata` is shifted right by `8*addr[1:0]`, then sign- or zero-extended per `d_len`.
- Error cases, with no memory access (`mem_en`=0):
  - Misaligned access: half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Illegal `d_len` (011, 110, 111).
  - The request is still granted. The FSM goes to `D_WAIT`, which asserts `d_valid` and `d_err`, with `d_rdata`=0.
- Requesters must keep `addr`, `we`, `len` and `wdata` stable until valid. Only the issue-cycle values are used.
- Dropping a request before issue cancels it with no side effect. Dropping it after issue still produces the valid pulse, which must be ignored.

## Timing
- Reset state: FSM `IDLE`, `last_grant`=fetch. All outputs 0, except `stall` and `mem_*`, which follow their combinational definitions.
- Reset assertion mid-access: the FSM returns to `IDLE` immediately. The pending valid pulse and the response are discarded.
- Fetch latency: request seen in `IDLE` at cycle N gives `mem_en`@N and `if_valid`/`if_rdata`@N+1.
- Data latency: the same, N gives `d_valid`@N+1. Store write occurs at the N→N+1 edge.
- Throughput: one access per 2 cycles. An access can issue again at N+2.
- Fetch delayed behind data:
  - Both requests present at N: data completes @N+1, fetch issues @N+2 and completes @N+3.
  - `stall` stays high N..N+2 for the fetch.
- `stall` is fully combinational. It deasserts in the same cycle as the last valid.

## Test plan
- Fetch only: `if_addr`=0x100, memory[0x100]=0x00500093. Expect `mem_en`@N, `if_valid`@N+1, `if_rdata`=0x00500093, `stall` N only.
- Both requesters at N:
  - Expect a data grant first, `d_valid`@N+1, then fetch `mem_en`@N+2 and `if_valid`@N+3.
  - Repeat the contention with `last_grant`=data: expect fetch first.
- Stores to word 0x200 initially 0:
  - sb 0xAB @0x201: `mem_be`=0010, word becomes 0x0000AB00.
  - sh 0x1234 @0x202: `mem_be`=1100, word becomes 0x1234AB00.
- Loads from word 0x200=0x80FF7F01:
  - lb @0x201 gives 0x0000007F. lb @0x202 gives 0xFFFFFFFF.
  - lbu @0x203 gives 0x00000080. lh @0x202 gives 0xFFFF80FF. lhu @0x202 gives 0x000080FF. lw @0x200 gives 0x80FF7F01.
- Misaligned lw @0x202 or sh @0x203: `mem_en` never asserted, `d_valid`@N+1 with `d_err`=1 and `d_rdata`=0, memory unchanged.
- Reset mid-access:
  - Deassert `RST` in `D_WAIT`: `d_valid`=0 immediately, FSM in `IDLE`.
  - After release, a held `d_req` is re-issued cleanly.
